// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream / ALU / transmitter bundle seen by the command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int FUN_W = 4
);
  logic [7:0]       rx_p_data;
  logic             rx_d_vld;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [FUN_W-1:0] alu_fun;
  logic             alu_en;
  logic [WIDTH-1:0] alu_out;
  logic             out_valid;
  logic [7:0]       tx_p_data;
  logic             tx_d_vld;
  logic             tx_busy;
  logic             done;
  logic             err;

  modport master (
    input  rx_p_data, rx_d_vld, alu_out, out_valid, tx_busy,
    output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, done, err
  );

  modport slave (
    output rx_p_data, rx_d_vld, alu_out, out_valid, tx_busy,
    input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, done, err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Collects fun/A/B from the RX byte stream, fires one ALU op, and streams the
// result LSB byte first to the transmitter; aborts with ERR if the ALU stalls.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int FUN_W   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.master bus
);
  localparam int NB = WIDTH / 8;
  localparam int MX = (NB > TIMEOUT) ? NB : TIMEOUT;
  localparam int CW = $clog2(MX) + 1;

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, ALU_REQ, ALU_WAIT, TX_SEND} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    byte_cnt, byte_cnt_n, tmo_cnt, tmo_cnt_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n, res_q, res_n, res_sh;
  logic [FUN_W-1:0] fun_q, fun_n;
  logic [7:0]       txd_q, txd_n;
  logic             en_q, en_n, txv_q, txv_n, done_q, done_n, err_q, err_n;
  logic             last_byte;

  assign last_byte = (byte_cnt == CW'(NB - 1));
  // Result is shifted down as bytes go out, so the low byte is always next.
  assign res_sh    = res_q >> 8;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      fun_q    <= '0;
      txd_q    <= '0;
      en_q     <= 1'b0;
      txv_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      tmo_cnt  <= tmo_cnt_n;
      a_q      <= a_n;
      b_q      <= b_n;
      res_q    <= res_n;
      fun_q    <= fun_n;
      txd_q    <= txd_n;
      en_q     <= en_n;
      txv_q    <= txv_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    tmo_cnt_n  = tmo_cnt;
    a_n        = a_q;
    b_n        = b_q;
    res_n      = res_q;
    fun_n      = fun_q;
    txd_n      = txd_q;
    txv_n      = txv_q;
    en_n       = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: if (bus.rx_d_vld) begin
        fun_n      = bus.rx_p_data[FUN_W-1:0];
        byte_cnt_n = '0;
        state_n    = GET_A;
      end
      GET_A: if (bus.rx_d_vld) begin
        a_n[8*int'(byte_cnt) +: 8] = bus.rx_p_data;
        byte_cnt_n = last_byte ? '0 : byte_cnt + 1'b1;
        if (last_byte) state_n = GET_B;
      end
      GET_B: if (bus.rx_d_vld) begin
        b_n[8*int'(byte_cnt) +: 8] = bus.rx_p_data;
        byte_cnt_n = last_byte ? '0 : byte_cnt + 1'b1;
        if (last_byte) begin
          en_n    = 1'b1;
          state_n = ALU_REQ;
        end
      end
      ALU_REQ: begin
        tmo_cnt_n = '0;
        state_n   = ALU_WAIT;
      end
      ALU_WAIT: begin
        // A valid result takes priority over a timeout in the same cycle.
        if (bus.out_valid) begin
          res_n      = bus.alu_out;
          txd_n      = bus.alu_out[7:0];
          txv_n      = 1'b1;
          byte_cnt_n = '0;
          state_n    = TX_SEND;
        end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      TX_SEND: if (!bus.tx_busy) begin
        if (last_byte) begin
          txv_n      = 1'b0;
          done_n     = 1'b1;
          byte_cnt_n = '0;
          state_n    = IDLE;
        end else begin
          byte_cnt_n = byte_cnt + 1'b1;
          res_n      = res_sh;
          txd_n      = res_sh[7:0];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_fun   = fun_q;
  assign bus.alu_en    = en_q;
  assign bus.tx_p_data = txd_q;
  assign bus.tx_d_vld  = txv_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule
